// File: rtl/oldland_timer_if.sv
// oldland_timer_if: oldland data-bus access/ack/error handshake between the CPU side and a responder.
interface oldland_timer_if;
   logic        cs;
   logic        d_access;
   logic [29:0] d_addr;
   logic        d_wr_en;
   logic [3:0]  d_bytesel;
   logic [31:0] d_wr_val;
   logic [31:0] d_data;
   logic        d_ack;
   logic        d_error;
   modport master(output cs, d_access, d_addr, d_wr_en, d_bytesel, d_wr_val, input d_data, d_ack, d_error);
   modport slave(input cs, d_access, d_addr, d_wr_en, d_bytesel, d_wr_val, output d_data, d_ack, d_error);
endinterface

// File: rtl/oldland_timer.sv
// oldland_timer: memory-mapped multi-channel down-counting timer with per-channel interrupts.
module oldland_timer #(
   parameter int NUM_TIMERS = 4
) (
   input  logic            clk,
   input  logic            rst,
   oldland_timer_if.slave  bus,
   output logic            irq_req
);
   typedef enum logic {IDLE, RESP} state_t;
   state_t                state, state_d;
   logic [31:0]           count [NUM_TIMERS];
   logic [31:0]           reload [NUM_TIMERS];
   logic [NUM_TIMERS-1:0] en, per, ie, pend, sel, expire;
   logic [1:0]            ch, rg;
   logic                  accept, bad, wr, ack_q, err_q;
   logic [31:0]           rdata, data_q;
   assign ch = bus.d_addr[3:2];
   assign rg = bus.d_addr[1:0];
   assign accept = state == IDLE && bus.cs && bus.d_access;
   assign bad = {30'd0, ch} >= NUM_TIMERS || (bus.d_wr_en && bus.d_bytesel != 4'hf);
   assign wr = accept && !bad && bus.d_wr_en;
   // A reset during RESP must swallow the response already queued in the output registers.
   assign bus.d_ack = ack_q && !rst;
   assign bus.d_error = err_q && !rst;
   assign bus.d_data = rst ? 32'd0 : data_q;
   always_comb begin
      state_d = accept ? RESP : IDLE;
   end
   always_comb begin
      rdata = '0;
      sel = '0;
      expire = '0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
         sel[i] = wr && ch == 2'(i);
         expire[i] = en[i] && count[i] == 32'd0;
         if (ch == 2'(i))
            rdata = rg == 2'd0 ? count[i] :
                    rg == 2'd1 ? reload[i] :
                    rg == 2'd2 ? {29'd0, ie[i], per[i], en[i]} : {31'd0, pend[i]};
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ack_q <= 1'b0;
         err_q <= 1'b0;
         data_q <= '0;
         irq_req <= 1'b0;
         en <= '0;
         per <= '0;
         ie <= '0;
         pend <= '0;
         for (int i = 0; i < NUM_TIMERS; i++) begin
            count[i] <= '0;
            reload[i] <= '0;
         end
      end else begin
         state <= state_d;
         ack_q <= accept && !bad;
         err_q <= accept && bad;
         data_q <= (accept && !bad && !bus.d_wr_en) ? rdata : 32'd0;
         irq_req <= |(pend & ie);
         for (int i = 0; i < NUM_TIMERS; i++) begin
            // Bus writes to COUNT/RELOAD take priority over decrement and reload.
            count[i] <= (sel[i] && !rg[1]) ? bus.d_wr_val :
                        (en[i] && count[i] != 32'd0) ? count[i] - 32'd1 :
                        (expire[i] && per[i]) ? reload[i] : count[i];
            if (sel[i] && rg == 2'd1)
               reload[i] <= bus.d_wr_val;
            if (sel[i] && rg == 2'd2)
               {ie[i], per[i], en[i]} <= bus.d_wr_val[2:0];
            else if (expire[i] && !per[i])
               en[i] <= 1'b0;
            pend[i] <= expire[i] || (pend[i] && !(sel[i] && rg == 2'd3 && bus.d_wr_val[0]));
         end
      end
   end
endmodule

// File: tb/tb_oldland_timer.sv
// tb_oldland_timer: directed vector table plus hand-written multi-cycle sequences for oldland_timer.
module tb_oldland_timer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic irq_req;
   logic last_irq;
   int   n_cmp = 0;
   int   n_bad = 0;
   always #5 clk = ~clk;
   oldland_timer_if bif();
   oldland_timer #(.NUM_TIMERS(3)) dut (.clk(clk), .rst(rst), .bus(bif), .irq_req(irq_req));
   typedef struct {
      logic        wr;
      logic [3:0]  a;
      logic [31:0] v;
      logic [3:0]  bs;
      logic        ack;
      logic        err;
      logic [31:0] d;
   } vec_t;
   vec_t tbl[$];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic bus(input logic wr, input logic [3:0] a, input logic [31:0] v, input logic [3:0] bs,
                      output logic [31:0] rd, output logic ack, output logic err);
      bif.cs = 1'b1;
      bif.d_access = 1'b1;
      bif.d_addr = {26'd0, a};
      bif.d_wr_en = wr;
      bif.d_bytesel = bs;
      bif.d_wr_val = v;
      @(posedge clk);
      #1;
      bif.cs = 1'b0;
      bif.d_access = 1'b0;
      @(negedge clk);
      rd = bif.d_data;
      ack = bif.d_ack;
      err = bif.d_error;
      last_irq = irq_req;
      @(posedge clk);
      #1;
   endtask
   task automatic wreg(input string nm, input logic [3:0] a, input logic [31:0] v);
      logic [31:0] rd;
      logic ack, err;
      bus(1'b1, a, v, 4'hf, rd, ack, err);
      chk({nm, " ack"}, 32'(ack), 32'd1);
   endtask
   task automatic rreg(input string nm, input logic [3:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      logic ack, err;
      bus(1'b0, a, 32'd0, 4'h0, rd, ack, err);
      chk({nm, " ack"}, 32'(ack), 32'd1);
      chk(nm, rd, exp);
   endtask
   initial begin
      logic [31:0] rd;
      logic ack, err;
      int pulses;
      bif.cs = 1'b0;
      bif.d_access = 1'b0;
      bif.d_addr = '0;
      bif.d_wr_en = 1'b0;
      bif.d_bytesel = 4'h0;
      bif.d_wr_val = '0;
      for (int i = 0; i < 16; i++)
         tbl.push_back('{1'b0, 4'(i), 32'd0, 4'h0, i < 12, i >= 12, 32'd0});
      tbl.push_back('{1'b1, 4'd2,  32'hFFFF_FFFA, 4'hF, 1'b1, 1'b0, 32'd0});
      tbl.push_back('{1'b0, 4'd2,  32'd0,         4'h0, 1'b1, 1'b0, 32'h2});
      tbl.push_back('{1'b1, 4'd5,  32'h1234,      4'h3, 1'b0, 1'b1, 32'd0});
      tbl.push_back('{1'b0, 4'd5,  32'd0,         4'h0, 1'b1, 1'b0, 32'd0});
      tbl.push_back('{1'b1, 4'd5,  32'h1234,      4'hF, 1'b1, 1'b0, 32'd0});
      tbl.push_back('{1'b0, 4'd4,  32'd0,         4'h5, 1'b1, 1'b0, 32'h1234});
      tbl.push_back('{1'b1, 4'd13, 32'h1,         4'hF, 1'b0, 1'b1, 32'd0});
      tbl.push_back('{1'b1, 4'd11, 32'h0,         4'hF, 1'b1, 1'b0, 32'd0});
      tbl.push_back('{1'b0, 4'd11, 32'd0,         4'h0, 1'b1, 1'b0, 32'd0});
      tbl.push_back('{1'b1, 4'd0,  32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 32'd0});
      tbl.push_back('{1'b0, 4'd0,  32'd0,         4'hF, 1'b1, 1'b0, 32'hDEAD_BEEF});
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset irq", 32'(irq_req), 32'd0);
      chk("reset ack", 32'(bif.d_ack), 32'd0);
      foreach (tbl[k]) begin
         bus(tbl[k].wr, tbl[k].a, tbl[k].v, tbl[k].bs, rd, ack, err);
         chk($sformatf("vec%0d ack", k), 32'(ack), 32'(tbl[k].ack));
         chk($sformatf("vec%0d err", k), 32'(err), 32'(tbl[k].err));
         chk($sformatf("vec%0d data", k), rd, tbl[k].d);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      // One-shot on ch0: expiry 6 edges after the CONTROL write, irq one edge later.
      wreg("os reload", 4'd1, 32'd5);
      wreg("os ctrl", 4'd2, 32'd5);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("os irq early", 32'(irq_req), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("os irq rise", 32'(irq_req), 32'd1);
      rreg("os count", 4'd0, 32'd0);
      rreg("os control", 4'd2, 32'd4);
      rreg("os status", 4'd3, 32'd1);
      wreg("os w1c", 4'd3, 32'd1);
      chk("os irq in ack", 32'(last_irq), 32'd1);
      @(negedge clk);
      chk("os irq fall", 32'(irq_req), 32'd0);
      // Periodic on ch1: expiries at 4, 8 edges after the CONTROL write.
      wreg("per reload", 4'd5, 32'd3);
      wreg("per ctrl", 4'd6, 32'd7);
      repeat (3) @(posedge clk);
      #1;
      wreg("per w1c", 4'd7, 32'd1);
      chk("per irq set", 32'(last_irq), 32'd1);
      @(negedge clk);
      chk("per irq cleared", 32'(irq_req), 32'd0);
      @(posedge clk);
      #1;
      wreg("per w1c expiry", 4'd7, 32'd1);
      chk("per irq before", 32'(last_irq), 32'd0);
      @(negedge clk);
      chk("per irq reset by set", 32'(irq_req), 32'd1);
      rreg("per status", 4'd7, 32'd1);
      wreg("per stop", 4'd6, 32'd0);
      wreg("per clr", 4'd7, 32'd1);
      @(negedge clk);
      chk("per irq off", 32'(irq_req), 32'd0);
      // ch2 write collision: written COUNT replaces the decrement in its cycle.
      wreg("col reload", 4'd9, 32'd1000);
      wreg("col ctrl", 4'd10, 32'd1);
      wreg("col count", 4'd8, 32'd100);
      rreg("col readback", 4'd8, 32'd99);
      bus(1'b1, 4'd9, 32'd7, 4'b0011, rd, ack, err);
      chk("bytesel err", 32'(err), 32'd1);
      chk("bytesel ack", 32'(ack), 32'd0);
      rreg("bytesel reload kept", 4'd9, 32'd1000);
      // d_access held through RESP must still produce exactly one response.
      pulses = 0;
      bif.cs = 1'b1;
      bif.d_access = 1'b1;
      bif.d_addr = 30'd3;
      bif.d_wr_en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         pulses += int'(bif.d_ack) + int'(bif.d_error);
         if (k == 1) begin
            @(posedge clk);
            #1;
            bif.cs = 1'b0;
            bif.d_access = 1'b0;
         end
      end
      chk("held pulses", 32'(pulses), 32'd1);
      // Reset while in RESP drops the response and clears every register.
      bif.cs = 1'b1;
      bif.d_access = 1'b1;
      bif.d_addr = 30'd8;
      bif.d_wr_en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      bif.cs = 1'b0;
      bif.d_access = 1'b0;
      @(negedge clk);
      chk("rresp ack", 32'(bif.d_ack), 32'd0);
      chk("rresp err", 32'(bif.d_error), 32'd0);
      chk("rresp data", bif.d_data, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rresp ack after", 32'(bif.d_ack), 32'd0);
      chk("rresp irq", 32'(irq_req), 32'd0);
      rreg("rresp count2", 4'd8, 32'd0);
      rreg("rresp reload2", 4'd9, 32'd0);
      rreg("rresp ctrl2", 4'd10, 32'd0);
      rreg("rresp reload0", 4'd1, 32'd0);
      rreg("rresp reload1", 4'd5, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
